// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: symbol width, port count, and the frame and
// assembler-state types used by the input buffering stage.
package xbar_pkg;

  localparam int unsigned packet_width = 8;
  localparam int unsigned ports        = 8;

  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } ib_state_t;

  typedef logic [2*packet_width-1:0] frame_t;

endpackage

// File: rtl/ib_frame_fifo.sv
// Per-channel frame FIFO: power-of-two depth, wrapping pointers, occupancy
// counter. A pop frees a slot in the same cycle, so push+pop succeeds when full.
module ib_frame_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty flag masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/input_frame_buffer.sv
// Input frame buffer: per-channel header/payload assembly into frame FIFOs,
// with a single read port steered by rd_sel toward the switch.
module input_frame_buffer
  import xbar_pkg::*;
#(
  parameter int unsigned PKT_W = packet_width,
  parameter int unsigned N_CH  = ports,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk10,
  input  logic [N_CH*PKT_W-1:0]   dec_in,
  input  logic [N_CH-1:0]         sym_valid,
  input  logic [N_CH-1:0]         sof,
  input  logic [$clog2(N_CH)-1:0] rd_sel,
  input  logic                    rd_en,
  output logic [2*PKT_W-1:0]      frame_out,
  output logic                    frame_valid,
  output logic [N_CH-1:0]         empty,
  output logic [N_CH-1:0]         full,
  output logic [N_CH-1:0]         drop_pulse,
  output logic [N_CH-1:0]         err_pulse
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [2*PKT_W-1:0] head [N_CH];
  logic [N_CH-1:0]    sel_hit;
  logic [N_CH-1:0]    pop;

  always_comb begin
    sel_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sel_hit[i] = (SEL_W'(i) == rd_sel);
    end
  end

  assign pop = sel_hit & ~empty & {N_CH{rd_en}};

  // Heads of empty FIFOs already read zero, so an OR of the selected head suffices.
  always_comb begin
    frame_out   = '0;
    frame_valid = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel_hit[i]) begin
        frame_out   = frame_out | head[i];
        frame_valid = frame_valid | ~empty[i];
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ib_state_t        state;
    logic [PKT_W-1:0] hdr;
    logic [PKT_W-1:0] sym;
    logic             sym_ev;
    logic             push;
    logic             drop_q;
    logic             err_q;

    assign sym    = dec_in[c*PKT_W +: PKT_W];
    assign sym_ev = clk10 & sym_valid[c];
    assign push   = sym_ev & (state == PAY) & ~sof[c];

    always_ff @(posedge clk) begin
      if (!rst) begin
        state  <= HDR;
        hdr    <= '0;
        drop_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        drop_q <= 1'b0;
        err_q  <= 1'b0;
        if (sym_ev) begin
          unique case (state)
            HDR: begin
              if (sof[c]) begin
                hdr   <= sym;
                state <= PAY;
              end
            end
            PAY: begin
              if (sof[c]) begin
                err_q <= 1'b1;
                hdr   <= sym;
              end else begin
                state  <= HDR;
                drop_q <= full[c] & ~pop[c];
              end
            end
          endcase
        end
      end
    end

    ib_frame_fifo #(
      .WIDTH (2*PKT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop[c]),
      .din   ({hdr, sym}),
      .dout  (head[c]),
      .empty (empty[c]),
      .full  (full[c])
    );

    assign drop_pulse[c] = drop_q;
    assign err_pulse[c]  = err_q;
  end

endmodule

// File: tb/tb_input_frame_buffer.sv
// Self-checking bench for input_frame_buffer: directed frame scenarios plus
// randomized traffic against a queue-based reference model.
module tb_input_frame_buffer;
  import xbar_pkg::*;

  localparam int PW = 8;
  localparam int NC = 8;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk10;
  logic [NC*PW-1:0] dec_in;
  logic [NC-1:0]   sym_valid;
  logic [NC-1:0]   sof;
  logic [2:0]      rd_sel;
  logic            rd_en;
  logic [2*PW-1:0] frame_out;
  logic            frame_valid;
  logic [NC-1:0]   empty;
  logic [NC-1:0]   full;
  logic [NC-1:0]   drop_pulse;
  logic [NC-1:0]   err_pulse;

  input_frame_buffer #(
    .PKT_W (PW),
    .N_CH  (NC),
    .DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk10       (clk10),
    .dec_in      (dec_in),
    .sym_valid   (sym_valid),
    .sof         (sof),
    .rd_sel      (rd_sel),
    .rd_en       (rd_en),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .empty       (empty),
    .full        (full),
    .drop_pulse  (drop_pulse),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored frames per channel, plus "a header is pending".
  frame_t          mq [NC][$];
  bit              have_hdr [NC];
  logic [PW-1:0]   mhdr [NC];
  logic [NC-1:0]   exp_drop;
  logic [NC-1:0]   exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      have_hdr[c] = 1'b0;
      mhdr[c]     = '0;
    end
    exp_drop = '0;
    exp_err  = '0;
  endtask

  task automatic check_outputs(input logic [2:0] sel);
    logic [NC-1:0] ee;
    logic [NC-1:0] ef;
    for (int c = 0; c < NC; c++) begin
      ee[c] = (mq[c].size() == 0);
      ef[c] = (mq[c].size() == D);
    end
    check("empty", 64'(empty), 64'(ee));
    check("full", 64'(full), 64'(ef));
    check("frame_valid", 64'(frame_valid), 64'(mq[sel].size() > 0));
    check("frame_out", 64'(frame_out), (mq[sel].size() > 0) ? 64'(mq[sel][0]) : 64'd0);
    check("drop_pulse", 64'(drop_pulse), 64'(exp_drop));
    check("err_pulse", 64'(err_pulse), 64'(exp_err));
  endtask

  // Called with clk low: drive, check current outputs, take one edge, update model.
  task automatic step(input bit r, input bit c10, input logic [NC*PW-1:0] d,
                      input logic [NC-1:0] v, input logic [NC-1:0] s,
                      input logic [2:0] sel, input bit re);
    logic [PW-1:0] sy;
    rst = r; clk10 = c10; dec_in = d; sym_valid = v; sof = s; rd_sel = sel; rd_en = re;
    #1;
    check_outputs(sel);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      exp_drop = '0;
      exp_err  = '0;
      if (re && mq[sel].size() > 0) void'(mq[sel].pop_front());
      for (int c = 0; c < NC; c++) begin
        sy = d[c*PW +: PW];
        if (c10 && v[c]) begin
          if (!have_hdr[c]) begin
            if (s[c]) begin
              mhdr[c]     = sy;
              have_hdr[c] = 1'b1;
            end
          end else if (s[c]) begin
            exp_err[c] = 1'b1;
            mhdr[c]    = sy;
          end else begin
            have_hdr[c] = 1'b0;
            if (mq[c].size() < D) mq[c].push_back({mhdr[c], sy});
            else exp_drop[c] = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic sym_on(input int c, input logic [PW-1:0] val, input bit s,
                        input logic [2:0] sel, input bit re);
    logic [NC*PW-1:0] d;
    logic [NC-1:0]    v;
    logic [NC-1:0]    sv;
    d = '0; v = '0; sv = '0;
    d[c*PW +: PW] = val;
    v[c]  = 1'b1;
    sv[c] = s;
    step(1'b1, 1'b1, d, v, sv, sel, re);
  endtask

  task automatic idle(input logic [2:0] sel, input bit re);
    step(1'b1, 1'b0, '0, '0, '0, sel, re);
  endtask

  initial begin
    rst = 1'b0; clk10 = 1'b0; dec_in = '0; sym_valid = '0; sof = '0; rd_sel = '0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("reset_empty", 64'(empty), 64'hFF);
    check("reset_fout", 64'(frame_out), 64'd0);
    step(1'b1, 1'b0, '0, '0, '0, 3'd0, 1'b0);

    // Basic frame on channel 0.
    sym_on(0, 8'hA5, 1'b1, 3'd0, 1'b0);
    sym_on(0, 8'h3C, 1'b0, 3'd0, 1'b0);
    check("ch0_fout", 64'(frame_out), 64'hA53C);
    check("ch0_fvalid", 64'(frame_valid), 64'd1);
    idle(3'd0, 1'b1);
    check("ch0_empty", 64'(empty[0]), 64'd1);

    // Overfill channel 2: fifth frame dropped.
    for (int k = 1; k <= 5; k++) begin
      sym_on(2, 8'(k), 1'b1, 3'd0, 1'b0);
      sym_on(2, 8'(k), 1'b0, 3'd0, 1'b0);
      if (k == 4) check("ch2_full", 64'(full[2]), 64'd1);
      if (k == 5) check("ch2_drop", 64'(drop_pulse[2]), 64'd1);
    end
    idle(3'd2, 1'b0);
    check("ch2_drop_clear", 64'(drop_pulse[2]), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      rd_sel = 3'd2; #1;
      check("ch2_order", 64'(frame_out), 64'({8'(k), 8'(k)}));
      idle(3'd2, 1'b1);
    end
    check("ch2_empty", 64'(empty[2]), 64'd1);

    // Full channel 1 with simultaneous pop and push.
    for (int k = 0; k < 4; k++) begin
      sym_on(1, 8'h10 + 8'(k), 1'b1, 3'd0, 1'b0);
      sym_on(1, 8'h20 + 8'(k), 1'b0, 3'd0, 1'b0);
    end
    sym_on(1, 8'h55, 1'b1, 3'd1, 1'b0);
    sym_on(1, 8'h66, 1'b0, 3'd1, 1'b1);
    check("ch1_nodrop", 64'(drop_pulse[1]), 64'd0);
    check("ch1_full", 64'(full[1]), 64'd1);
    for (int k = 0; k < 4; k++) idle(3'd1, 1'b1);

    // Framing error on channel 3.
    sym_on(3, 8'h11, 1'b1, 3'd3, 1'b0);
    sym_on(3, 8'h22, 1'b1, 3'd3, 1'b0);
    check("ch3_err", 64'(err_pulse[3]), 64'd1);
    sym_on(3, 8'h33, 1'b0, 3'd3, 1'b0);
    check("ch3_err_once", 64'(err_pulse[3]), 64'd0);
    check("ch3_frame", 64'(frame_out), 64'h2233);
    idle(3'd3, 1'b1);

    // Reset mid-frame on channel 4.
    for (int k = 0; k < 2; k++) begin
      sym_on(4, 8'h40, 1'b1, 3'd4, 1'b0);
      sym_on(4, 8'h41, 1'b0, 3'd4, 1'b0);
    end
    sym_on(4, 8'h42, 1'b1, 3'd4, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 3'd4, 1'b0);
    check("ch4_rst_empty", 64'(empty), 64'hFF);
    check("ch4_rst_fvalid", 64'(frame_valid), 64'd0);
    sym_on(4, 8'h43, 1'b0, 3'd4, 1'b0);
    check("ch4_no_push", 64'(empty[4]), 64'd1);

    // Gated symbols: clk10 low or sym_valid low must not advance anything.
    step(1'b1, 1'b0, {NC{8'h77}}, '1, '1, 3'd5, 1'b0);
    step(1'b1, 1'b1, {NC{8'h78}}, '0, '1, 3'd5, 1'b0);
    sym_on(5, 8'h79, 1'b0, 3'd5, 1'b0);
    check("gated_empty", 64'(empty), 64'hFF);

    // Randomized traffic; long enough for many pointer wraps.
    for (int n = 0; n < 4000; n++) begin
      logic [NC*PW-1:0] d;
      logic [NC-1:0] v;
      logic [NC-1:0] s;
      d = {$urandom(), $urandom()};
      v = NC'($urandom());
      s = NC'($urandom() & $urandom());
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0), d, v, s,
           3'($urandom()), ($urandom_range(0, 3) == 0));
    end
    idle(3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_frame_buffer.md
INPUT_FRAME_BUFFER -- requirements
Module: input_frame_buffer

Interface
REQ-001 Parameter PKT_W, default packet_width from xbar_pkg (8): width of one decoded symbol (header or payload).
REQ-002 Parameter N_CH, default ports from xbar_pkg (8): number of input channels buffered.
REQ-003 Parameter DEPTH, default 4: frames stored per channel; power of two, >=2.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 clk10  in  1  symbol strobe, one-cycle pulse; all symbol inputs sampled only when high.
REQ-007 dec_in  in  N_CH*PKT_W  decoded symbols; channel c at bits [c*PKT_W +: PKT_W].
REQ-008 sym_valid  in  N_CH  per-channel symbol qualifier.
REQ-009 sof  in  N_CH  per-channel start-of-frame marker; high means this symbol is a header.
REQ-010 rd_sel  in  $clog2(N_CH)  channel presented to the switch.
REQ-011 rd_en  in  1  pop request for channel rd_sel.
REQ-012 frame_out  out  2*PKT_W  {header,payload} at head of channel rd_sel.
REQ-013 frame_valid  out  1  channel rd_sel is non-empty.
REQ-014 empty / full  out  N_CH each  per-channel FIFO status.
REQ-015 drop_pulse  out  N_CH  one-cycle pulse: completed frame discarded, FIFO full.
REQ-016 err_pulse  out  N_CH  one-cycle pulse: framing error (sof seen mid-frame).

Function
REQ-017 Each channel SHALL run an independent assembler FSM, states HDR and PAY; only cycles with clk10 && sym_valid[c] are symbol events.
REQ-018 HDR, event, sof=1: header register <= symbol, next PAY; HDR, event, sof=0: symbol discarded, stay HDR.
REQ-019 PAY, event, sof=0: frame complete {header,symbol}; push if not full, else drop_pulse[c]=1 and frame discarded; next HDR.
REQ-020 PAY, event, sof=1: err_pulse[c]=1, partial frame discarded, symbol taken as new header, stay PAY.
REQ-021 Non-event cycles SHALL leave FSM state and header register unchanged.
REQ-022 A pushed frame SHALL be visible (frame_valid, frame_out) in the cycle after the completing-event edge (latency 1 clk).
REQ-023 frame_out SHALL be combinational from head entry of rd_sel and SHALL read 0 when frame_valid=0.
REQ-024 rd_en && frame_valid SHALL pop rd_sel at the clock edge; rd_en with frame_valid=0 SHALL be ignored, no pointer change.
REQ-025 Push and pop on the same channel in the same cycle SHALL both succeed, including when full (occupancy unchanged, no drop).
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width $clog2(DEPTH)+1; full at DEPTH, empty at 0.
REQ-027 Channels not selected by rd_sel SHALL never be popped; rd_sel change takes effect combinationally.
REQ-028 drop_pulse and err_pulse SHALL be registered, high exactly one cycle per event.

Reset
REQ-029 rst=0 at posedge: all FSMs HDR, all FIFOs empty, empty=all-1, full=0, frame_valid=0, frame_out=0, drop_pulse=0, err_pulse=0.
REQ-030 Reset mid-frame SHALL discard partial and stored frames; no pulse SHALL be generated by reset.
REQ-031 Storage arrays need not be reset; outputs SHALL not expose them while empty.

Structure
REQ-032 xbar_pkg SHALL hold packet_width, ports, typedef ib_state_t {HDR,PAY}, typedef frame_t (2*packet_width packed).
REQ-033 Per-channel FIFO SHALL be sub-module ib_frame_fifo (params WIDTH, DEPTH), instantiated N_CH times by generate; assembler FSM stays in the top.

Verification
REQ-034 Ch0: sof=1 hdr 0xA5 then sof=0 pay 0x3C on clk10 events, rd_sel=0 -> next cycle frame_valid=1, frame_out=0xA53C; rd_en -> empty[0]=1.
REQ-035 Ch2: 5 frames 0x0101..0x0505, no reads, DEPTH=4 -> full[2]=1 after 4th, drop_pulse[2] one cycle on 5th; reads return 0x0101..0x0404 in order.
REQ-036 Ch1 full, rd_sel=1, rd_en in same cycle as completing payload event -> no drop, full[1] stays 1, new frame at tail.
REQ-037 Ch3: hdr 0x11 (sof=1), then 0x22 with sof=1, then payload 0x33 -> err_pulse[3] once, stored frame 0x2233.
REQ-038 Ch4: 2 frames stored, header of 3rd captured, rst=0 one cycle -> empty all-1, frame_valid=0; next payload (sof=0) discarded, nothing pushed.
REQ-039 Symbols with sym_valid=0 or clk10=0 and sof=0 at HDR -> no state change, no push; 10 wraps of DEPTH pointers preserve FIFO order.
